store_rs_scheduler: RTL and testbench

Scheduler for the bank of store reservation-station lines. It allocates a free store entry on issue, keeps the program order of allocated entries, and dispatches the oldest store to the memory unit once its data operand is ready. It then frees that entry with a one-cycle `result_taken` pulse. It sits between the issue stage, the N store RS lines and the data-memory port.

---
 rtl/store_rs_scheduler.sv | 163 ++++++++++++++++
 tb/tb_store_rs_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/store_rs_scheduler.sv
// Store reservation-station scheduler: in-order allocation queue plus a single-outstanding memory port.
// Optional stall counter enabled by defining STORE_SCHED_PERF_CNT_EN.
module store_rs_scheduler #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            issue_req,
   output logic [N-1:0]    issue_grant,
   output logic            full,
   output logic            empty,
   input  logic [N-1:0]    rs_busy,
   input  logic [N-1:0]    rs_data_ready,
   input  logic [N*32-1:0] rs_addr,
   input  logic [N*32-1:0] rs_data,
   input  logic [N*3-1:0]  rs_width,
   output logic [N-1:0]    result_taken,
   output logic            mem_req,
   output logic [31:0]     mem_addr,
   output logic [31:0]     mem_data,
   output logic [2:0]      mem_width,
`ifdef STORE_SCHED_PERF_CNT_EN
   output logic [31:0]     stall_cycles,
`endif
   input  logic            mem_ack
);

   typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   fifo_q [N];
   logic [IW-1:0]   head_q, tail_q;
   logic [IW:0]     count_q;
   logic [N-1:0]    queued_q, queued_d;
   logic [N-1:0]    result_taken_q;
   logic [31:0]     mem_addr_q, mem_data_q;
   logic [2:0]      mem_width_q;

   logic [IW-1:0]   grant_idx;
   logic            grant_found;
   logic            push, pop, latch;
   logic [IW-1:0]   head_idx;

   assign head_idx = fifo_q[head_q];
   assign full     = (count_q == (IW+1)'(N));
   assign empty    = (count_q == '0);

   // Lowest free line that is not busy and not already waiting in the queue.
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!rs_busy[i] && !queued_q[i]) begin
            grant_found = 1'b1;
            grant_idx   = IW'(i);
         end
      end
      push        = issue_req && !full && !flush && grant_found;
      issue_grant = '0;
      if (push) issue_grant[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty && rs_data_ready[head_idx] && !flush) begin
               state_d = StReq;
               latch   = 1'b1;
            end
         end
         StReq: begin
            if (mem_ack) begin
               state_d = StIdle;
               pop     = !flush;
            end else if (flush) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (mem_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      queued_d = queued_q;
      if (flush) begin
         queued_d = '0;
      end else begin
         if (pop)  queued_d[head_idx]  = 1'b0;
         if (push) queued_d[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= StIdle;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         queued_q       <= '0;
         result_taken_q <= '0;
         mem_addr_q     <= '0;
         mem_data_q     <= '0;
         mem_width_q    <= '0;
         for (int i = 0; i < N; i++) fifo_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         queued_q       <= queued_d;
         result_taken_q <= '0;
         if (pop) result_taken_q[head_idx] <= 1'b1;
         if (latch) begin
            mem_addr_q  <= rs_addr[32*head_idx +: 32];
            mem_data_q  <= rs_data[32*head_idx +: 32];
            mem_width_q <= rs_width[3*head_idx +: 3];
         end
         if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (push) begin
               fifo_q[tail_q] <= grant_idx;
               tail_q         <= tail_q + 1'b1;
            end
            if (pop) head_q <= head_q + 1'b1;
            unique case ({push, pop})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
      end
   end

   assign result_taken = result_taken_q;
   assign mem_req      = (state_q != StIdle);
   assign mem_addr     = mem_addr_q;
   assign mem_data     = mem_data_q;
   assign mem_width    = mem_width_q;

`ifdef STORE_SCHED_PERF_CNT_EN
   logic [31:0] stall_q;

   // Saturating; deliberately survives flush.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (state_q == StIdle && !empty && !rs_data_ready[head_idx] && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_store_rs_scheduler.sv
// Randomized bench for store_rs_scheduler against a queue-based reference model.
module tb_store_rs_scheduler;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst, flush, issue_req, mem_ack;
   logic [N-1:0]    issue_grant, rs_busy, rs_data_ready, result_taken;
   logic            full, empty, mem_req;
   logic [N*32-1:0] rs_addr, rs_data;
   logic [N*3-1:0]  rs_width;
   logic [31:0]     mem_addr, mem_data;
   logic [2:0]      mem_width;
`ifdef STORE_SCHED_PERF_CNT_EN
   logic [31:0]     stall_cycles;
`endif

   store_rs_scheduler #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .issue_req    (issue_req),
      .issue_grant  (issue_grant),
      .full         (full),
      .empty        (empty),
      .rs_busy      (rs_busy),
      .rs_data_ready(rs_data_ready),
      .rs_addr      (rs_addr),
      .rs_data      (rs_data),
      .rs_width     (rs_width),
      .result_taken (result_taken),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .mem_width    (mem_width),
`ifdef STORE_SCHED_PERF_CNT_EN
      .stall_cycles (stall_cycles),
`endif
      .mem_ack      (mem_ack)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: program-ordered list of allocated lines and the memory port view.
   int          q[$];
   bit [N-1:0]  busy_m;
   logic [31:0] e_addr [N];
   logic [31:0] e_data [N];
   logic [2:0]  e_width[N];
   int          port_st;   // 0 idle, 1 awaiting ack, 2 draining after flush
   logic [31:0] m_addr, m_data;
   logic [2:0]  m_width;
   logic [N-1:0] rt_m;
   logic [31:0] stall_m;

   function automatic bit in_q(input int idx);
      foreach (q[k]) if (q[k] == idx) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step(input bit r, input bit f, input bit iq, input logic [N-1:0] rdy,
                       input bit ack);
      logic [N-1:0] g_exp, rt_next;
      int           g_idx;
      @(negedge clk);
      rst = r; flush = f; issue_req = iq; rs_data_ready = rdy; mem_ack = ack;
      rs_busy = busy_m;
      for (int i = 0; i < N; i++) begin
         rs_addr[32*i +: 32] = e_addr[i];
         rs_data[32*i +: 32] = e_data[i];
         rs_width[3*i +: 3]  = e_width[i];
      end
      #1;
      g_exp = '0;
      g_idx = -1;
      if (iq && q.size() < N && !f) begin
         for (int i = 0; i < N; i++) begin
            if (g_idx < 0 && !busy_m[i] && !in_q(i)) g_idx = i;
         end
         if (g_idx >= 0) g_exp[g_idx] = 1'b1;
      end
      check("issue_grant", 32'(issue_grant), 32'(g_exp));
      check("full", 32'(full), 32'(q.size() == N));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("mem_req", 32'(mem_req), 32'(port_st != 0));
      check("mem_addr", mem_addr, m_addr);
      check("mem_data", mem_data, m_data);
      check("mem_width", 32'(mem_width), 32'(m_width));
      check("result_taken", 32'(result_taken), 32'(rt_m));
`ifdef STORE_SCHED_PERF_CNT_EN
      check("stall_cycles", stall_cycles, stall_m);
`endif
      // Advance the model by one clock edge.
      if (!r) begin
         q.delete(); busy_m = '0; port_st = 0; rt_m = '0;
         m_addr = '0; m_data = '0; m_width = '0; stall_m = '0;
         return;
      end
      if (port_st == 0 && q.size() > 0 && !rdy[q[0]] && stall_m != 32'hFFFF_FFFF) stall_m++;
      rt_next = '0;
      case (port_st)
         0: if (q.size() > 0 && rdy[q[0]] && !f) begin
               port_st = 1;
               m_addr = e_addr[q[0]]; m_data = e_data[q[0]]; m_width = e_width[q[0]];
            end
         1: if (ack) begin
               port_st = 0;
               if (!f) begin
                  rt_next[q[0]] = 1'b1;
                  void'(q.pop_front());
               end
            end else if (f) port_st = 2;
         default: if (ack) port_st = 0;
      endcase
      busy_m = busy_m & ~rt_m;
      if (f) begin
         q.delete();
         busy_m = '0;
      end else if (g_idx >= 0) begin
         q.push_back(g_idx);
         busy_m[g_idx] = 1'b1;
         e_addr[g_idx]  = $urandom;
         e_data[g_idx]  = $urandom;
         e_width[g_idx] = 3'($urandom_range(0, 7));
      end
      rt_m = rt_next;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         e_addr[i] = '0; e_data[i] = '0; e_width[i] = '0;
      end
      busy_m = '0; port_st = 0; rt_m = '0; stall_m = '0;
      m_addr = '0; m_data = '0; m_width = '0;
      rst = 1'b0; flush = 1'b0; issue_req = 1'b0; mem_ack = 1'b0;
      rs_busy = '0; rs_data_ready = '0; rs_addr = '0; rs_data = '0; rs_width = '0;

      step(0, 0, 0, '0, 0);
      step(0, 0, 0, '0, 0);
      // Fill all four lines, then a fifth request must be refused.
      for (int i = 0; i < 5; i++) step(1, 0, 1, '0, 0);
      e_addr[0] = 32'h100; e_data[0] = 32'hDEADBEEF; e_width[0] = 3'b010;
      // Younger entry 1 ready while head 0 is not: nothing may dispatch.
      step(1, 0, 0, 4'b0010, 0);
      step(1, 0, 0, 4'b0010, 0);
      check("in_order_hold", 32'(mem_req), 32'd0);
      step(1, 0, 0, 4'b0011, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 4'b0011, 0);
      check("dir_addr", mem_addr, 32'h100);
      check("dir_data", mem_data, 32'hDEADBEEF);
      step(1, 0, 0, 4'b0011, 1);
      step(1, 0, 0, 4'b0011, 0);
      check("dir_taken", 32'(result_taken), 32'b0001);
      // Entry 1 next, then flush while it is outstanding.
      step(1, 0, 0, 4'b0010, 0);
      step(1, 1, 0, 4'b0010, 0);
      step(1, 0, 0, 4'b0000, 0);
      check("drain_req", 32'(mem_req), 32'd1);
      check("drain_empty", 32'(empty), 32'd1);
      step(1, 0, 0, 4'b0000, 1);
      step(1, 0, 0, 4'b0000, 0);
      // Reset while a store is outstanding.
      step(1, 0, 1, '0, 0);
      step(1, 0, 0, 4'b1111, 0);
      step(0, 0, 0, 4'b1111, 0);
      step(1, 0, 0, 4'b0000, 0);
      check("rst_mid_req", 32'(mem_req), 32'd0);

      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(0, 99) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
              N'($urandom), $urandom_range(0, 2) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
